// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the four-digit multiplexed seven-segment scanner:
// segment patterns (active-low, bit0 = a ... bit6 = g) and the anode one-hot table.
package display_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int PRESC_W    = 26;
    localparam int FRAME_W    = 8;

    typedef logic [1:0] digit_ptr_t;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Entry n is the active-low enable for digit n.
    localparam logic [NUM_DIGITS-1:0][NUM_DIGITS-1:0] ANODE_TABLE =
        {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle of the scanner's load handshake, display controls and display drive outputs.
interface display_scan_ctrl_if;
    import display_scan_ctrl_pkg::*;

    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    load;
    logic                    load_ack;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blank_lead;
    logic [NUM_DIGITS-1:0]   anode;
    logic [SEG_W-1:0]        seg;
    logic                    frame_tick;

    modport master (
        output enable, digits, load, blink_mask, blank_lead,
        input  load_ack, anode, seg, frame_tick
    );

    modport slave (
        input  enable, digits, load, blink_mask, blank_lead,
        output load_ack, anode, seg, frame_tick
    );

endinterface

// File: rtl/display_scan_ctrl_bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with frame-synchronous shadow loading,
// per-digit blinking and leading-zero suppression.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 128
)
(
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [1:0]            rst_sync;
    logic                  run;
    logic [0:0]            state;
    logic [PRESC_W-1:0]    presc;
    digit_ptr_t            ptr;
    logic [FRAME_W-1:0]    frame_cnt;
    logic                  blink_phase;
    logic                  pending;
    logic [15:0]           shadow;
    logic [NUM_DIGITS-1:0] anode_q;
    logic [SEG_W-1:0]      seg_q;
    logic                  load_ack_q;

    logic                  scan_active;
    logic                  frame_tick;
    logic                  capture;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] lead_blank;
    logic                  digit_blank;
    logic [SEG_W-1:0]      dec_seg;

    // Reset asserts immediately but is released through two flops so no state moves on the release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_comb begin
        scan_active = run && (state == ST_SCAN) && bus.enable;
        frame_tick  = scan_active && (presc == PRESC_LAST) && (ptr == 2'd3);
        if (state == ST_SCAN) begin
            capture = frame_tick && (pending || bus.load);
        end else begin
            capture = run && pending;
        end
        nibble     = shadow[{ptr, 2'b00} +: 4];
        lead_blank = '0;
        if (bus.blank_lead) begin
            lead_blank[3] = (shadow[15:12] == 4'h0);
            lead_blank[2] = lead_blank[3] && (shadow[11:8] == 4'h0);
            lead_blank[1] = lead_blank[2] && (shadow[7:4] == 4'h0);
        end
        digit_blank = (blink_phase && bus.blink_mask[ptr]) || lead_blank[ptr];
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // A load seen during the acknowledge cycle is the tail of the request just served, not a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            presc       <= '0;
            ptr         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            pending     <= 1'b0;
            shadow      <= '0;
        end else if (run) begin
            state <= bus.enable ? ST_SCAN : ST_IDLE;
            if (scan_active) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    ptr   <= ptr + 2'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
                if (frame_tick) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end else begin
                presc       <= '0;
                ptr         <= '0;
                frame_cnt   <= '0;
                blink_phase <= 1'b0;
            end
            if (capture) begin
                shadow  <= bus.digits;
                pending <= 1'b0;
            end else if (bus.load && !load_ack_q) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q    <= ANODE_OFF;
            seg_q      <= SEG_BLANK;
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= capture;
            if (run && bus.enable) begin
                anode_q <= ANODE_TABLE[ptr];
                seg_q   <= digit_blank ? SEG_BLANK : dec_seg;
            end else begin
                anode_q <= ANODE_OFF;
                seg_q   <= SEG_BLANK;
            end
        end
    end

    assign bus.anode      = anode_q;
    assign bus.seg        = seg_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random traffic,
// all compared against a cycle-count based reference model.
module tb_display_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = 4 * SCAN_DIV;

    logic clk;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: m_n counts scanning cycles since SCAN was entered.
    bit          m_scan;
    int          m_n;
    bit          m_pending;
    logic [15:0] m_shadow;
    int          m_hold;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic        exp_ack;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [6:0] refSeg(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic bit leadBlanked(input logic [15:0] s, input int k);
        bit all_zero = (k != 0);
        for (int j = k; j < 4; j++) begin
            if (s[4*j +: 4] != 4'h0) all_zero = 1'b0;
        end
        return all_zero;
    endfunction

    function automatic bit expFrameTick();
        return (m_hold == 0) && m_scan && bus.enable && ((m_n % FRAME_LEN) == FRAME_LEN - 1);
    endfunction

    task automatic modelReset();
        m_scan    = 1'b0;
        m_n       = 0;
        m_pending = 1'b0;
        m_shadow  = 16'h0000;
        m_hold    = 0;
        exp_anode = 4'b1111;
        exp_seg   = 7'b1111111;
        exp_ack   = 1'b0;
    endtask

    task automatic modelEdge();
        int         ptr;
        logic [1:0] p;
        bit         phase;
        bit         blank;
        bit         capture;
        logic [3:0] one;
        one = 4'b0001;
        if (m_hold > 0) begin
            m_hold--;
            exp_anode = 4'b1111;
            exp_seg   = 7'b1111111;
            exp_ack   = 1'b0;
            return;
        end
        ptr   = (m_n / SCAN_DIV) % 4;
        p     = 2'(ptr);
        phase = (((m_n / FRAME_LEN) / BLINK_FRAMES) % 2) == 1;
        if (bus.enable) begin
            exp_anode = ~(one << p);
            blank     = (phase && bus.blink_mask[p]) || (bus.blank_lead && leadBlanked(m_shadow, ptr));
            exp_seg   = blank ? 7'b1111111 : refSeg(m_shadow[4*ptr +: 4]);
        end else begin
            exp_anode = 4'b1111;
            exp_seg   = 7'b1111111;
        end
        capture = m_scan ? (expFrameTick() && (m_pending || bus.load)) : m_pending;
        exp_ack = capture;
        if (capture) begin
            m_shadow  = bus.digits;
            m_pending = 1'b0;
        end else if (bus.load) begin
            m_pending = 1'b1;
        end
        m_n    = (m_scan && bus.enable) ? m_n + 1 : 0;
        m_scan = bus.enable;
    endtask

    task automatic runCycle();
        #1;
        checkOutput("frame_tick", 32'(bus.frame_tick), 32'(expFrameTick()));
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkOutput("anode", 32'(bus.anode), 32'(exp_anode));
        checkOutput("seg", 32'(bus.seg), 32'(exp_seg));
        checkOutput("load_ack", 32'(bus.load_ack), 32'(exp_ack));
        if (exp_ack || bus.load_ack) bus.load = 1'b0;
    endtask

    task automatic loadDigits(input logic [15:0] value);
        logic seen;
        seen       = 1'b0;
        bus.digits = value;
        bus.load   = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            runCycle();
            if (bus.load_ack) seen = 1'b1;
        end
        checkOutput("load_ack_seen", 32'(seen), 32'd1);
    endtask

    // Asserts reset between clock edges so the outputs must go dark without a clock.
    task automatic pulseReset();
        #3;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        #1;
        modelReset();
        checkOutput("async_anode", 32'(bus.anode), 32'(exp_anode));
        checkOutput("async_seg", 32'(bus.seg), 32'(exp_seg));
        checkOutput("async_ack", 32'(bus.load_ack), 32'(exp_ack));
        checkOutput("async_tick", 32'(bus.frame_tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("held_anode", 32'(bus.anode), 32'(exp_anode));
        rst_n  = 1'b1;
        m_hold = 2;
    endtask

    task automatic applyStimulus();
        logic [15:0] d;
        if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
        if (!bus.load && !exp_ack && $urandom_range(0, 11) == 0) begin
            for (int k = 0; k < 4; k++) begin
                d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            end
            bus.digits = d;
            bus.load   = 1'b1;
        end
        if ($urandom_range(0, 99) == 0) bus.blink_mask = 4'($urandom);
        if ($urandom_range(0, 99) == 0) bus.blank_lead = ~bus.blank_lead;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.digits     = 16'h0000;
        bus.load       = 1'b0;
        bus.blink_mask = 4'b0000;
        bus.blank_lead = 1'b0;
        modelReset();

        @(negedge clk);
        checkOutput("reset_anode", 32'(bus.anode), 32'(exp_anode));
        checkOutput("reset_seg", 32'(bus.seg), 32'(exp_seg));
        checkOutput("reset_ack", 32'(bus.load_ack), 32'(exp_ack));
        rst_n  = 1'b1;
        m_hold = 2;

        // Basic scan of 1234 loaded while idle.
        loadDigits(16'h1234);
        bus.enable = 1'b1;
        repeat (3 * FRAME_LEN) runCycle();

        // Mid-frame reload only takes effect at the frame boundary.
        repeat (6) runCycle();
        loadDigits(16'h5678);
        repeat (2 * FRAME_LEN) runCycle();

        // Leading-zero suppression.
        bus.blank_lead = 1'b1;
        loadDigits(16'h0007);
        repeat (2 * FRAME_LEN + 4) runCycle();
        loadDigits(16'h0000);
        repeat (2 * FRAME_LEN) runCycle();
        bus.blank_lead = 1'b0;

        // Blinking digit0 holding a non-BCD nibble.
        bus.blink_mask = 4'b0001;
        loadDigits(16'hA12A);
        repeat (5 * FRAME_LEN) runCycle();
        bus.blink_mask = 4'b0000;

        // Disable at digit 2 with a load outstanding, then re-enable.
        for (int i = 0; i < FRAME_LEN && ((m_n / SCAN_DIV) % 4) != 2; i++) runCycle();
        bus.digits = 16'h9081;
        bus.load   = 1'b1;
        runCycle();
        bus.enable = 1'b0;
        repeat (4) runCycle();
        bus.enable = 1'b1;
        repeat (2 * FRAME_LEN) runCycle();

        // Reset during a pending load.
        bus.digits = 16'h4321;
        bus.load   = 1'b1;
        runCycle();
        pulseReset();
        repeat (2 * FRAME_LEN) runCycle();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) pulseReset();
            applyStimulus();
            runCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SCAN_DIV, 100000, Clock cycles each digit is driven; legal range 2..2^26-1.
REQ-002 BLINK_FRAMES, 128, full frames per blink half-period; legal range 1..255.
REQ-003 Clock  in  1  single system clock; all state updates on rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Enable  in  1  1 = scan display, 0 = display dark.
REQ-006 Digits  in  16  four BCD nibbles; [3:0] = digit0 (rightmost), [15:12] = digit3.
REQ-007 Load  in  1  request to take Digits into the display shadow register; Digits held stable until LoadAck.
REQ-008 LoadAck  out  1  one-cycle pulse: Digits captured.
REQ-009 BlinkMask  in  4  bit n = 1 makes digit n blink.
REQ-010 BlankLead  in  1  1 = suppress leading zeros.
REQ-011 Anode  out  4  active-low digit enables, at most one bit low.
REQ-012 Seg  out  7  active-low segments; Seg[0] = a ... Seg[6] = g.
REQ-013 FrameTick  out  1  one-cycle pulse when the digit pointer wraps 3 -> 0.

Function
REQ-014 Two states: IDLE (Enable = 0) and SCAN (Enable = 1); IDLE -> SCAN on Enable = 1, SCAN -> IDLE on Enable = 0, both taking effect at the next edge.
REQ-015 SCAN: 26-bit prescaler counts 0..SCAN_DIV-1; at terminal count it clears and the 2-bit digit pointer increments, wrapping 3 -> 0.
REQ-016 IDLE: prescaler, pointer, frame counter and blink phase held at 0; Anode = 4'b1111, Seg = 7'b1111111.
REQ-017 Anode and Seg are registered; they reflect the pointer one cycle after it changes; the first SCAN cycle after IDLE drives digit0 (Anode = 4'b1110).
REQ-018 Pointer-to-anode map: 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-019 Seg decode of the shadow nibble: 0..9 standard patterns (0 = 7'b1000000, 8 = 7'b0000000); 10..15 = dash 7'b0111111.
REQ-020 Load sets a pending flag; Load while pending has no further effect.
REQ-021 In SCAN the shadow register captures Digits only on a FrameTick cycle with pending set, or with Load high in that same cycle; pending clears; LoadAck pulses the following cycle.
REQ-022 In IDLE a pending load is captured at the next edge, LoadAck the cycle after.
REQ-023 Dropping Enable mid-frame keeps the pending flag and shadow register intact.
REQ-024 Frame counter (8-bit) increments on FrameTick; at BLINK_FRAMES-1 it clears and the blink phase toggles.
REQ-025 Blink phase = 1: digits with BlinkMask set drive Seg = 7'b1111111 while their anode stays low.
REQ-026 BlankLead = 1: digit3 blanked if 0; digit2 blanked if digit3 and digit2 are 0; digit1 blanked if digits 3..1 are 0; digit0 never blanked.
REQ-027 Blanking evaluates the shadow register, never the live Digits input.

Reset
REQ-028 Reset_n = 0 immediately forces: state IDLE, all counters 0, pointer 0, blink phase 0, pending 0, shadow 16'h0000, Anode 4'b1111, Seg 7'b1111111, LoadAck 0, FrameTick 0.
REQ-029 Reset mid-load discards the request; no LoadAck follows reset release.
REQ-030 Reset release is synchronized; first state change no earlier than the second rising edge after deassertion.

Structure
REQ-031 Shared package holds the segment pattern constants (digits 0..9, dash, blank) and the anode one-hot table.
REQ-032 One sub-module, bcd_to_seg7 (combinational nibble -> Seg); everything else lives in display_scan_ctrl.

Verification (SCAN_DIV = 4, BLINK_FRAMES = 2)
REQ-033 Reset, Enable = 1, Digits = 16'h1234 loaded -> Anode cycles 1110/1101/1011/0111 every 4 cycles; Seg shows 4, 3, 2, 1; FrameTick every 16 cycles.
REQ-034 Load 16'h5678 mid-frame -> display unchanged until FrameTick; LoadAck one cycle later; next frame shows 8, 7, 6, 5.
REQ-035 Shadow 16'h0007, BlankLead = 1 -> digits 3..1 Seg = 1111111, digit0 shows 7; shadow 16'h0000 -> digit0 shows 0.
REQ-036 BlinkMask = 4'b0001 -> digit0 is lit 2 frames, blank 2 frames, repeating; other digits are unaffected; nibble 4'hA shows dash.
REQ-037 Enable dropped at pointer 2 with a pending load -> next cycle all off; LoadAck follows within 2 cycles; re-enable starts at digit0.
REQ-038 Reset_n pulsed low during a pending load -> outputs go dark asynchronously; no LoadAck; shadow reads 0 after reset release.
